// File: rtl/branch_resolver.sv
// branch_resolver: resolves stage-2 branches from Comparator eq/lt flags,
// issues a held PC redirect to fetch, follows it with a timed flush, and
// keeps saturating counts of resolved and taken conditional branches.
module branch_resolver #(
    parameter int PC_WIDTH     = 32,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 br_valid,
    input  logic                 is_jal,
    input  logic                 is_jalr,
    input  logic [2:0]           funct3,
    input  logic [PC_WIDTH-1:0]  target,
    input  logic                 stall,
    input  logic                 cmp_eq,
    input  logic                 cmp_lt,
    output logic                 cmp_s,
    output logic                 redirect_valid,
    output logic [PC_WIDTH-1:0]  redirect_pc,
    input  logic                 redirect_ready,
    output logic                 flush,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] branch_cnt,
    output logic [CNT_WIDTH-1:0] taken_cnt
);

    // Flush countdown width; at least one bit so FLUSH_CYCLES of 0 or 1 still elaborates.
    localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FC_W-1:0] FLUSH_LOAD = (FLUSH_CYCLES > 0) ? FC_W'(FLUSH_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REDIRECT = 2'd1,
        ST_FLUSH    = 2'd2
    } state_t;

    state_t              state_reg, state_next;
    logic [FC_W-1:0]     cnt_reg, cnt_next;
    logic [PC_WIDTH-1:0] redirect_pc_reg, redirect_pc_next;

    logic is_uncond;
    logic cond_legal;
    logic cond_taken;
    logic taken;
    logic accept;
    logic [1:0] cnt_inc;

    // Branch decode: comparator signedness, legality and taken decision.
    always_comb begin
        is_uncond  = is_jal | is_jalr;
        cmp_s      = 1'b1;
        cond_legal = 1'b1;
        cond_taken = 1'b0;
        case (funct3)
            3'b000: cond_taken = cmp_eq;
            3'b001: cond_taken = ~cmp_eq;
            3'b100: cond_taken = cmp_lt;
            3'b101: cond_taken = ~cmp_lt;
            3'b110: begin
                cond_taken = cmp_lt;
                cmp_s      = 1'b0;
            end
            3'b111: begin
                cond_taken = ~cmp_lt;
                cmp_s      = 1'b0;
            end
            default: begin
                // 010/011 are not branch encodings: never taken, never counted.
                cond_taken = 1'b0;
                cond_legal = 1'b0;
            end
        endcase
        taken      = is_uncond | (cond_legal & cond_taken);
        accept     = br_valid & ~stall & (state_reg == ST_IDLE);
        cnt_inc[0] = accept & ~is_uncond & cond_legal;
        cnt_inc[1] = accept & ~is_uncond & cond_legal & cond_taken;
    end

    // Next-state logic for the redirect/flush sequencer.
    always_comb begin
        state_next       = state_reg;
        cnt_next         = cnt_reg;
        redirect_pc_next = redirect_pc_reg;
        case (state_reg)
            ST_IDLE: begin
                if (accept && taken) begin
                    state_next = ST_REDIRECT;
                    // JALR targets always have bit 0 cleared.
                    redirect_pc_next = is_jalr ? {target[PC_WIDTH-1:1], 1'b0} : target;
                end
            end
            ST_REDIRECT: begin
                if (redirect_ready) begin
                    if (FLUSH_CYCLES == 0) begin
                        state_next = ST_IDLE;
                    end else begin
                        state_next = ST_FLUSH;
                        cnt_next   = FLUSH_LOAD;
                    end
                end
            end
            ST_FLUSH: begin
                if (cnt_reg == '0) begin
                    state_next = ST_IDLE;
                end else begin
                    cnt_next = cnt_reg - FC_W'(1);
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Sequencer state, flush countdown and held redirect target.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= ST_IDLE;
            cnt_reg         <= '0;
            redirect_pc_reg <= '0;
        end else begin
            state_reg       <= state_next;
            cnt_reg         <= cnt_next;
            redirect_pc_reg <= redirect_pc_next;
        end
    end

    assign redirect_valid = (state_reg == ST_REDIRECT);
    assign flush          = (state_reg != ST_IDLE);
    assign busy           = (state_reg != ST_IDLE);
    assign redirect_pc    = redirect_pc_reg;

    // Index 0 counts resolved conditional branches, index 1 counts taken ones.
    for (genvar gi = 0; gi < 2; gi++) begin : gen_cnt
        logic [CNT_WIDTH-1:0] count_reg;

        // Saturating event counter; holds at all-ones instead of wrapping.
        always_ff @(posedge clk) begin
            if (reset) begin
                count_reg <= '0;
            end else if (cnt_inc[gi] && (count_reg != '1)) begin
                count_reg <= count_reg + CNT_WIDTH'(1);
            end
        end
    end

    assign branch_cnt = gen_cnt[0].count_reg;
    assign taken_cnt  = gen_cnt[1].count_reg;

endmodule
